// File: rtl/p_decode_fork.sv
// ============================================================================
// Module   : p_decode_fork
// Brief    : Forks one upstream request to a decoded/masked set of downstream
//            channels and joins their acks into a single completion pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module p_decode_fork #(
  parameter int NCH    = 4,
  parameter int SELW   = 5,
  parameter int MCAST  = 0,
  parameter int SHIFT  = 3,
  parameter int TO_CYC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            t_kp_req,
  output logic            t_kp_ack,
  input  logic [SELW-1:0] k_ctrl,
  output logic [NCH-1:0]  i_req,
  input  logic [NCH-1:0]  i_ack,
  output logic            busy,
  output logic            err_empty,
  output logic            timeout
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t         r_state;
  logic [NCH-1:0] r_sel;
  logic [NCH-1:0] r_done;
  logic [NCH-1:0] w_sel_dec;
  logic [NCH-1:0] w_pend;
  logic           w_issue;
  logic           w_accept;

  if (MCAST != 0) begin : g_mcast
    logic w_unused_hi;
    assign w_unused_hi = ^k_ctrl;
    assign w_sel_dec   = k_ctrl[NCH-1:0];
  end else begin : g_range
    logic [31:0] w_idx;
    logic [31:0] w_idx_sat;
    assign w_idx     = 32'(k_ctrl) >> SHIFT;
    assign w_idx_sat = (w_idx >= 32'(NCH-1)) ? 32'(NCH-1) : w_idx;
    always_comb begin
      w_sel_dec = '0;
      for (int i = 0; i < NCH; i++) begin
        if (w_idx_sat == 32'(i)) w_sel_dec[i] = 1'b1;
      end
    end
  end

  assign w_issue   = (r_state == ST_ISSUE);
  assign w_accept  = (r_state == ST_IDLE) && t_kp_req;
  assign w_pend    = r_sel & ~r_done;
  // Requests come only from registers so downstream acks never loop back.
  assign i_req     = {NCH{w_issue}} & w_pend;
  assign t_kp_ack  = w_issue && ((w_pend & ~i_ack) == '0);
  assign busy      = w_issue;
  assign err_empty = w_issue && (r_sel == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (t_kp_req) begin
            r_state <= ST_ISSUE;
            r_sel   <= w_sel_dec;
            r_done  <= '0;
          end
        end
        ST_ISSUE: begin
          r_done <= r_done | (i_req & i_ack);
          if (t_kp_ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  if (TO_CYC > 0) begin : g_to
    localparam int CW = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(TO_CYC);
    logic [CW-1:0] r_to_cnt;

    // Saturates at TO_CYC so the pulse fires exactly once per transaction.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_to_cnt <= '0;
      end else if (w_accept) begin
        r_to_cnt <= '0;
      end else if (w_issue && (r_to_cnt != C_MAX)) begin
        r_to_cnt <= r_to_cnt + CW'(1);
      end
    end

    assign timeout = w_issue && (r_to_cnt == C_LAST);
  end else begin : g_no_to
    assign timeout = 1'b0;
  end

endmodule

`default_nettype wire

// File: tb/tb_p_decode_fork.sv
// ============================================================================
// Module   : tb_p_decode_fork
// Brief    : Directed self-checking bench for p_decode_fork (range, saturate,
//            multicast, empty mask, timeout, reset abandonment).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_p_decode_fork;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // Range decode, NCH=2
  logic       a_req = 1'b0, a_ack, a_busy, a_err, a_to;
  logic [4:0] a_ctrl = '0;
  logic [1:0] a_ireq, a_iack = '0;
  // Range decode with saturation, NCH=4
  logic       b_req = 1'b0, b_ack, b_busy, b_err, b_to;
  logic [4:0] b_ctrl = '0;
  logic [3:0] b_ireq, b_iack = '0;
  // Multicast with timeout, NCH=4
  logic       c_req = 1'b0, c_ack, c_busy, c_err, c_to;
  logic [4:0] c_ctrl = '0;
  logic [3:0] c_ireq, c_iack = '0;

  p_decode_fork #(.NCH(2), .SELW(5), .MCAST(0), .SHIFT(3), .TO_CYC(0)) u_r2 (
    .clk(clk), .reset(rst), .t_kp_req(a_req), .t_kp_ack(a_ack), .k_ctrl(a_ctrl),
    .i_req(a_ireq), .i_ack(a_iack), .busy(a_busy), .err_empty(a_err), .timeout(a_to));

  p_decode_fork #(.NCH(4), .SELW(5), .MCAST(0), .SHIFT(3), .TO_CYC(0)) u_r4 (
    .clk(clk), .reset(rst), .t_kp_req(b_req), .t_kp_ack(b_ack), .k_ctrl(b_ctrl),
    .i_req(b_ireq), .i_ack(b_iack), .busy(b_busy), .err_empty(b_err), .timeout(b_to));

  p_decode_fork #(.NCH(4), .SELW(5), .MCAST(1), .SHIFT(3), .TO_CYC(4)) u_mc (
    .clk(clk), .reset(rst), .t_kp_req(c_req), .t_kp_ack(c_ack), .k_ctrl(c_ctrl),
    .i_req(c_ireq), .i_ack(c_iack), .busy(c_busy), .err_empty(c_err), .timeout(c_to));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    #1;
    check("rst_ireq",  32'(c_ireq), 32'h0);
    check("rst_ack",   32'(c_ack),  32'h0);
    check("rst_busy",  32'(c_busy), 32'h0);
    check("rst_err",   32'(c_err),  32'h0);
    check("rst_to",    32'(c_to),   32'h0);
    check("rst_a_ireq", 32'(a_ireq), 32'h0);
    rst = 1'b0;

    // NCH=2, k_ctrl=5 -> channel 0, accepted on first edge after reset
    a_ctrl = 5'd5; a_req = 1'b1;
    tick();
    #1;
    check("r2_k5_ireq", 32'(a_ireq), 32'h1);
    check("r2_k5_noack", 32'(a_ack), 32'h0);
    check("r2_busy", 32'(a_busy), 32'h1);
    a_iack = 2'b01;
    #1;
    check("r2_k5_ack", 32'(a_ack), 32'h1);
    tick();
    a_req = 1'b0; a_iack = 2'b00;
    #1;
    check("r2_idle_ireq", 32'(a_ireq), 32'h0);
    check("r2_idle_busy", 32'(a_busy), 32'h0);

    // NCH=2, k_ctrl=12 -> channel 1
    a_ctrl = 5'd12; a_req = 1'b1;
    tick();
    #1;
    check("r2_k12_ireq", 32'(a_ireq), 32'h2);
    a_iack = 2'b10;
    #1;
    check("r2_k12_ack", 32'(a_ack), 32'h1);
    check("r2_no_to", 32'(a_to), 32'h0);
    tick();
    a_req = 1'b0; a_iack = 2'b00;

    // NCH=4, k_ctrl=31 saturates to channel 3; k_ctrl changes mid-ISSUE ignored
    b_ctrl = 5'd31; b_req = 1'b1;
    tick();
    b_ctrl = 5'd0;
    #1;
    check("r4_sat_ireq", 32'(b_ireq), 32'h8);
    tick();
    #1;
    check("r4_hold_ireq", 32'(b_ireq), 32'h8);
    b_iack = 4'b1000;
    #1;
    check("r4_sat_ack", 32'(b_ack), 32'h1);
    tick();
    b_req = 1'b0; b_iack = 4'b0000;

    // NCH=4, k_ctrl=20 -> channel 2
    b_ctrl = 5'd20; b_req = 1'b1;
    tick();
    b_req = 1'b0;
    #1;
    check("r4_k20_ireq", 32'(b_ireq), 32'h4);
    b_iack = 4'b0100;
    #1;
    check("r4_k20_ack", 32'(b_ack), 32'h1);
    tick();
    b_iack = 4'b0000;

    // Multicast 1011, out-of-order acks, req dropped mid-transaction
    c_ctrl = 5'b01011; c_req = 1'b1;
    tick();
    c_ctrl = 5'b00000; c_req = 1'b0;
    #1;
    check("mc_ireq0", 32'(c_ireq), 32'hB);
    c_iack = 4'b0110;
    #1;
    check("mc_ack0", 32'(c_ack), 32'h0);
    tick();
    c_iack = 4'b0000;
    #1;
    check("mc_ireq1", 32'(c_ireq), 32'h9);
    c_iack = 4'b1000;
    #1;
    check("mc_ack1", 32'(c_ack), 32'h0);
    tick();
    c_iack = 4'b0000;
    #1;
    check("mc_ireq2", 32'(c_ireq), 32'h1);
    c_iack = 4'b0001;
    #1;
    check("mc_ack2", 32'(c_ack), 32'h1);
    check("mc_to_none", 32'(c_to), 32'h0);
    tick();
    c_iack = 4'b0000;
    #1;
    check("mc_idle_busy", 32'(c_busy), 32'h0);
    check("mc_idle_ack", 32'(c_ack), 32'h0);

    // Empty mask
    c_ctrl = 5'b00000; c_req = 1'b1;
    tick();
    c_req = 1'b0;
    #1;
    check("empty_err", 32'(c_err), 32'h1);
    check("empty_ack", 32'(c_ack), 32'h1);
    check("empty_ireq", 32'(c_ireq), 32'h0);
    tick();
    #1;
    check("empty_err_off", 32'(c_err), 32'h0);
    check("empty_busy_off", 32'(c_busy), 32'h0);
    check("empty_ireq_off", 32'(c_ireq), 32'h0);

    // Timeout: no ack for 6 ISSUE cycles, pulse only in the 4th
    c_ctrl = 5'b00001; c_req = 1'b1;
    tick();
    c_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check($sformatf("to_cyc%0d", k), 32'(c_to), (k == 4) ? 32'h1 : 32'h0);
      if (k < 6) tick();
    end
    c_iack = 4'b0001;
    #1;
    check("to_late_ack", 32'(c_ack), 32'h1);
    tick();
    c_iack = 4'b0000;

    // Reset mid-transaction abandons it
    c_ctrl = 5'b00110; c_req = 1'b1;
    tick();
    #1;
    check("rmid_ireq", 32'(c_ireq), 32'h6);
    rst = 1'b1;
    #1;
    check("rmid_ireq0", 32'(c_ireq), 32'h0);
    check("rmid_ack0",  32'(c_ack),  32'h0);
    check("rmid_busy0", 32'(c_busy), 32'h0);
    check("rmid_err0",  32'(c_err),  32'h0);
    check("rmid_to0",   32'(c_to),   32'h0);
    c_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rmid_post_ack", 32'(c_ack), 32'h0);
    c_ctrl = 5'b00001; c_req = 1'b1;
    tick();
    c_req = 1'b0;
    #1;
    check("rmid_new_ireq", 32'(c_ireq), 32'h1);
    c_iack = 4'b0001;
    #1;
    check("rmid_new_ack", 32'(c_ack), 32'h1);
    tick();
    c_iack = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
